// File: rtl/cap_queue.sv
`default_nettype none
// ============================================================================
// Module      : cap_queue
// Description : Qualified-capture FIFO. A word is captured only when every
//               capture qualifier line is high. Head entry is presented
//               combinationally and forced to zero while empty. A sticky
//               overflow flag records captures that hit a full queue.
//               Optional macro CAP_OVERWRITE_EN: a capture into a full queue
//               with no pop overwrites the oldest entry instead of being
//               dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module cap_queue #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4,   // power of two, 2..64
    parameter int CAP_W  = 3
) (
    input  logic                       clock,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          data_in,
    input  logic [CAP_W-1:0]           capture,
    input  logic                       rd_en,
    input  logic                       clr_ovf,
    output logic [DATA_W-1:0]          data_out,
    output logic                       valid_out,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Storage and control state
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;
    logic              ovf_q,    ovf_d;

    // Decoded per-cycle events
    logic cap_req;
    logic is_valid;
    logic is_full;
    logic pop;
    logic push;
    logic ovf_event;
    logic wr_en;

    // Event decode, pointer/count/flag next-state
    always_comb begin
        cap_req   = &capture;
        is_valid  = (count_q != '0);
        is_full   = (count_q == CW'(DEPTH));
        pop       = rd_en & is_valid;
        // A simultaneous pop frees a slot, so a full queue can still accept.
        push      = cap_req & (~is_full | pop);
        ovf_event = cap_req & is_full & ~pop;

        wr_en     = push;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;

        // Pointers are AW bits wide, so incrementing wraps DEPTH-1 -> 0.
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

`ifdef CAP_OVERWRITE_EN
        // Full means wr_ptr == rd_ptr: write over the oldest slot and move
        // both pointers so the next-oldest entry becomes the head.
        if (ovf_event) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
`endif

        // Set wins over clear when both happen in one cycle.
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (ovf_event) begin
            ovf_d = 1'b1;
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage write; contents are not reset, they stay hidden behind count
    always_ff @(posedge clock) begin
        if (!rst && wr_en) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign valid_out = is_valid;
    assign full      = is_full;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign data_out  = is_valid ? mem_q[rd_ptr_q] : '0;

endmodule
`default_nettype wire

// File: doc/cap_queue.md
CAP_QUEUE -- requirements
Module: cap_queue

Interface
REQ-001 Parameter DATA_W, default 4, SHALL set the width of each captured data word.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of storage entries; legal values are powers of two, 2 to 64.
REQ-003 Parameter CAP_W, default 3, SHALL set the number of capture qualifier lines.
REQ-004 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 data_in  input  DATA_W  SHALL be the word to capture.
REQ-007 capture  input  CAP_W  SHALL be the capture qualifiers; a capture is requested only when all bits are 1.
REQ-008 rd_en  input  1  SHALL request a pop of the head entry.
REQ-009 clr_ovf  input  1  SHALL clear the sticky overflow flag.
REQ-010 data_out  output  DATA_W  SHALL present the head (oldest) entry.
REQ-011 valid_out  output  1  SHALL be 1 when at least one entry is stored.
REQ-012 full  output  1  SHALL be 1 when count equals DEPTH.
REQ-013 count  output  clog2(DEPTH)+1  SHALL give the number of stored entries.
REQ-014 overflow  output  1  SHALL be a sticky flag set when a capture hits a full queue.

Function
REQ-015 cap_req SHALL equal the AND-reduction of capture; a partial match SHALL have no effect.
REQ-016 Pop SHALL occur when rd_en=1 and valid_out=1; rd_en while empty SHALL be ignored with no state change.
REQ-017 Push SHALL occur when cap_req=1 and (full=0 or pop occurs in the same cycle).
REQ-018 Push and pop in one cycle SHALL leave count unchanged; this applies at empty+1, mid-range and full.
REQ-019 A pushed word SHALL appear on data_out, with valid_out=1, in the first cycle after the capturing edge if the queue was empty; there is no fall-through in the same cycle.
REQ-020 data_out SHALL be driven combinationally from registered storage at the read pointer, and SHALL be all-zero whenever valid_out=0.
REQ-021 Read and write pointers SHALL wrap from DEPTH-1 to 0; ordering SHALL be strictly FIFO.
REQ-022 count SHALL change by +1 on push only, -1 on pop only, and 0 otherwise; it SHALL never exceed DEPTH or underflow.
REQ-023 cap_req=1 with full=1 and no pop SHALL set overflow; the data handling is set by REQ-028 and REQ-029.
REQ-024 clr_ovf=1 SHALL clear overflow at the next edge; if an overflow event occurs in the same cycle, set SHALL win.

Reset
REQ-025 rst=1 at a clock edge SHALL clear the pointers, count, valid_out, full and overflow, and SHALL force data_out to 0; it overrides push, pop and clr_ovf in the same cycle.
REQ-026 Reset asserted mid-operation SHALL discard all stored entries; storage contents need not be cleared but SHALL never be visible.
REQ-027 The first push SHALL be accepted in the first cycle after rst deasserts.

Configuration
REQ-028 Without CAP_OVERWRITE_EN defined, a capture into a full queue with no pop SHALL be dropped; storage, pointers and count are unchanged.
REQ-029 With CAP_OVERWRITE_EN defined, that capture SHALL overwrite the oldest entry; both pointers advance, count stays DEPTH, and data_out shows the next-oldest entry.

Verification
REQ-030 Reset then capture=3'b111, data_in=4'hA for one cycle -> next cycle valid_out=1, data_out=4'hA, count=1; capture=3'b110 -> no push.
REQ-031 Push 4'h1..4'h4 (defaults) -> full=1, count=4; then four pops -> data_out sequence 1,2,3,4, then valid_out=0, data_out=0.
REQ-032 Full queue, push 4'h5 with rd_en=1 -> 4'h1 popped, count=4, overflow=0, later order 2,3,4,5.
REQ-033 Full queue (1..4), push 4'h9 without pop -> overflow=1; no macro: order 1,2,3,4; CAP_OVERWRITE_EN: order 2,3,4,9.
REQ-034 overflow=1, assert clr_ovf together with another full-queue capture -> overflow stays 1; clr_ovf alone next cycle -> overflow=0.
REQ-035 Two entries stored, rst=1 together with cap_req and rd_en -> next cycle count=0, valid_out=0, data_out=0, overflow=0.
